// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: owns the PC and the fetch enable, runs the IDLE/RUN/STALL/DRAIN
// sequence, and stalls fetch with a bubble into execute on RAW hazards.
module pipeline_ctrl #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] PC_RESET     = '0,
  parameter logic [XLEN-1:0] PC_STEP      = XLEN'(1),
  parameter logic [XLEN-1:0] PC_LAST      = XLEN'(63),
  parameter int unsigned     DRAIN_CYCLES = 3
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            start,
  input  logic            halt_req,
  input  logic [4:0]      rs1_de,
  input  logic [4:0]      rs2_de,
  input  logic            uses_rs1,
  input  logic            uses_rs2,
  input  logic [4:0]      rd_ex,
  input  logic            we_ex,
  input  logic [4:0]      rd_wb,
  input  logic            we_wb,
  output logic [XLEN-1:0] pc,
  output logic            fetch_enable,
  output logic            bubble_de,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [1:0]      state
);

  localparam int unsigned     CW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CW-1:0]   DRAIN_LOAD = CW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    STALL = 2'b10,
    DRAIN = 2'b11
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   drain_cnt_q, drain_cnt_d;
  logic            halt_pend_q, halt_pend_d;
  logic            done_q, done_d;

  logic hz1, hz2, hazard, active;

  // Writeback still counts as in flight: the regfile only updates at the closing edge.
  assign hz1 = uses_rs1 && (rs1_de != 5'd0) &&
               ((we_ex && (rd_ex == rs1_de)) || (we_wb && (rd_wb == rs1_de)));
  assign hz2 = uses_rs2 && (rs2_de != 5'd0) &&
               ((we_ex && (rd_ex == rs2_de)) || (we_wb && (rd_wb == rs2_de)));
  assign hazard = hz1 | hz2;

  assign active       = (state_q == RUN) || (state_q == STALL);
  assign stall        = active && hazard;
  assign fetch_enable = active && !hazard;
  assign bubble_de    = !fetch_enable;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign pc           = pc_q;
  assign state        = state_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drain_cnt_d = drain_cnt_q;
    halt_pend_d = halt_pend_q;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        pc_d = PC_RESET;
        if (start) state_d = RUN;
      end
      RUN, STALL: begin
        // Hazard wins over halt/last-fetch; a halt seen during a hazard is remembered.
        if (hazard) begin
          state_d = STALL;
          if (halt_req) halt_pend_d = 1'b1;
        end else if (halt_req || halt_pend_q || (pc_q == PC_LAST)) begin
          state_d     = DRAIN;
          drain_cnt_d = DRAIN_LOAD;
        end else begin
          state_d = RUN;
          pc_d    = pc_q + PC_STEP;
        end
      end
      DRAIN: begin
        if (drain_cnt_q == '0) begin
          state_d     = IDLE;
          done_d      = 1'b1;
          halt_pend_d = 1'b0;
          pc_d        = PC_RESET;
        end else begin
          drain_cnt_d = drain_cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      pc_q        <= PC_RESET;
      drain_cnt_q <= '0;
      halt_pend_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drain_cnt_q <= drain_cnt_d;
      halt_pend_q <= halt_pend_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: one instance with the default PC_LAST, one with
// PC_LAST=3 for the end-of-program drain.
module tb_pipeline_ctrl;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_STALL = 2'b10;
  localparam logic [1:0] S_DRAIN = 2'b11;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [6:0]  fl;
  } exp_t;

  logic clock, reset_n, rst3_n, use3;
  logic start, halt_req, uses_rs1, uses_rs2, we_ex, we_wb;
  logic [4:0] rs1_de, rs2_de, rd_ex, rd_wb;

  logic [31:0] pc_a, pc_b;
  logic fe_a, bub_a, stl_a, busy_a, done_a;
  logic fe_b, bub_b, stl_b, busy_b, done_b;
  logic [1:0] st_a, st_b;

  logic [31:0] pc_obs;
  logic [6:0]  fl_obs;

  exp_t sb[$];
  exp_t mon_e;
  event samp_ev;
  int   n_chk  = 0;
  int   n_fail = 0;

  pipeline_ctrl dut (
    .clock(clock), .reset_n(reset_n), .start(start), .halt_req(halt_req),
    .rs1_de(rs1_de), .rs2_de(rs2_de), .uses_rs1(uses_rs1), .uses_rs2(uses_rs2),
    .rd_ex(rd_ex), .we_ex(we_ex), .rd_wb(rd_wb), .we_wb(we_wb),
    .pc(pc_a), .fetch_enable(fe_a), .bubble_de(bub_a), .stall(stl_a),
    .busy(busy_a), .done(done_a), .state(st_a)
  );

  pipeline_ctrl #(.PC_LAST(32'd3)) dut3 (
    .clock(clock), .reset_n(rst3_n), .start(start), .halt_req(halt_req),
    .rs1_de(rs1_de), .rs2_de(rs2_de), .uses_rs1(uses_rs1), .uses_rs2(uses_rs2),
    .rd_ex(rd_ex), .we_ex(we_ex), .rd_wb(rd_wb), .we_wb(we_wb),
    .pc(pc_b), .fetch_enable(fe_b), .bubble_de(bub_b), .stall(stl_b),
    .busy(busy_b), .done(done_b), .state(st_b)
  );

  always_comb begin
    pc_obs = use3 ? pc_b : pc_a;
    fl_obs = use3 ? {st_b, fe_b, bub_b, stl_b, busy_b, done_b}
                  : {st_a, fe_a, bub_a, stl_a, busy_a, done_a};
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Flags are {state, fetch_enable, bubble_de, stall, busy, done}.
  initial begin
    forever begin
      @(negedge clock or samp_ev);
      while (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check({mon_e.tag, "_pc"}, 64'(pc_obs), 64'(mon_e.pc));
        check({mon_e.tag, "_fl"}, 64'(fl_obs), 64'(mon_e.fl));
      end
    end
  end

  function automatic exp_t mk(input string tag, input logic [31:0] epc, input logic [1:0] est,
                              input logic efe, input logic estl, input logic edone);
    exp_t e;
    e.tag = tag;
    e.pc  = epc;
    e.fl  = {est, efe, ~efe, estl, (est != S_IDLE), edone};
    return e;
  endfunction

  task automatic cyc(input string tag, input logic [31:0] epc, input logic [1:0] est,
                     input logic efe, input logic estl, input logic edone);
    sb.push_back(mk(tag, epc, est, efe, estl, edone));
    @(posedge clock);
    #1;
  endtask

  task automatic now_chk(input string tag, input logic [31:0] epc, input logic [1:0] est,
                         input logic efe, input logic estl, input logic edone);
    sb.push_back(mk(tag, epc, est, efe, estl, edone));
    -> samp_ev;
    #1;
  endtask

  task automatic clr_in();
    start = 0; halt_req = 0; uses_rs1 = 0; uses_rs2 = 0; we_ex = 0; we_wb = 0;
    rs1_de = '0; rs2_de = '0; rd_ex = '0; rd_wb = '0;
  endtask

  initial begin
    reset_n = 0; rst3_n = 0; use3 = 0;
    clr_in();
    @(posedge clock);
    #1;
    cyc("rst", 0, S_IDLE, 0, 0, 0);
    reset_n = 1;
    cyc("idle", 0, S_IDLE, 0, 0, 0);
    start = 1;
    cyc("start", 0, S_IDLE, 0, 0, 0);
    start = 0;
    for (int i = 0; i < 4; i++) cyc($sformatf("run%0d", i), 32'(i), S_RUN, 1, 0, 0);

    halt_req = 1;
    cyc("halt", 4, S_RUN, 1, 0, 0);
    halt_req = 0;
    for (int i = 0; i < 3; i++) cyc($sformatf("drain%0d", i), 4, S_DRAIN, 0, 0, 0);
    cyc("done", 0, S_IDLE, 0, 0, 1);
    start = 1;
    cyc("restart", 0, S_IDLE, 0, 0, 0);
    cyc("r0", 0, S_RUN, 1, 0, 0);
    start = 0;
    cyc("r1", 1, S_RUN, 1, 0, 0);

    rs1_de = 5; uses_rs1 = 1; rd_ex = 5; we_ex = 1;
    cyc("hz_ex", 2, S_RUN, 0, 1, 0);
    we_ex = 0; rd_wb = 5; we_wb = 1;
    cyc("hz_wb", 2, S_STALL, 0, 1, 0);
    we_wb = 0;
    cyc("resume", 2, S_STALL, 1, 0, 0);
    cyc("r3", 3, S_RUN, 1, 0, 0);

    rs1_de = 0; uses_rs1 = 1; rd_ex = 0; we_ex = 1;
    cyc("x0", 4, S_RUN, 1, 0, 0);
    uses_rs1 = 0; rs2_de = 7; uses_rs2 = 0; rd_ex = 7; we_ex = 1;
    cyc("nouse", 5, S_RUN, 1, 0, 0);
    uses_rs2 = 1;
    cyc("hz_rs2", 6, S_RUN, 0, 1, 0);
    halt_req = 1;
    cyc("st_halt", 6, S_STALL, 0, 1, 0);
    halt_req = 0;
    cyc("st_pend", 6, S_STALL, 0, 1, 0);
    we_ex = 0; uses_rs2 = 0;
    cyc("pend_go", 6, S_STALL, 1, 0, 0);
    halt_req = 1;
    for (int i = 0; i < 3; i++) cyc($sformatf("drainb%0d", i), 6, S_DRAIN, 0, 0, 0);
    halt_req = 0;
    cyc("done2", 0, S_IDLE, 0, 0, 1);

    start = 1;
    cyc("restart2", 0, S_IDLE, 0, 0, 0);
    start = 0;
    cyc("q0", 0, S_RUN, 1, 0, 0);
    rs1_de = 9; uses_rs1 = 1; rd_wb = 9; we_wb = 1;
    cyc("hz_wb2", 1, S_RUN, 0, 1, 0);
    cyc("pre_rst", 1, S_STALL, 0, 1, 0);
    #1;
    reset_n = 0;
    #1;
    now_chk("async_rst", 0, S_IDLE, 0, 0, 0);
    @(posedge clock);
    #1;
    cyc("rst_hold", 0, S_IDLE, 0, 0, 0);
    clr_in();

    use3 = 1;
    rst3_n = 1;
    cyc("l_idle", 0, S_IDLE, 0, 0, 0);
    start = 1;
    cyc("l_start", 0, S_IDLE, 0, 0, 0);
    start = 0;
    for (int i = 0; i < 3; i++) cyc($sformatf("l_run%0d", i), 32'(i), S_RUN, 1, 0, 0);
    cyc("l_last", 3, S_RUN, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc($sformatf("l_drain%0d", i), 3, S_DRAIN, 0, 0, 0);
    cyc("l_done", 0, S_IDLE, 0, 0, 1);
    cyc("l_idle2", 0, S_IDLE, 0, 0, 0);

    @(negedge clock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
